// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: six-digit multiplexed 7-segment scanner for the stopwatch.
// The segment bus is active-low (bit 7 = dp, bits 6..0 = g..a). The digit
// commons are active-low, and bit i selects display index i.
// All six digits are latched together once per frame, so a carry that ripples
// through the time counter mid-frame cannot tear the displayed value.
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zero minutes.
module seg_scan_ctrl #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       disp_en,
  input  logic [3:0] t_ms0,
  input  logic [3:0] t_ms1,
  input  logic [3:0] t_s0,
  input  logic [3:0] t_s1,
  input  logic [3:0] t_m0,
  input  logic [3:0] t_m1,
  output logic [7:0] seg_n,
  output logic [5:0] com_n
);

  typedef enum logic {ST_OFF, ST_SCAN} state_t;

  localparam logic [15:0] TICK_VAL = 16'(SCAN_DIV - 1);

  state_t      state_q, state_d;
  logic [15:0] presc_q, presc_d;
  logic [2:0]  idx_q, idx_d;
  logic [23:0] snap_q, snap_d;
  logic [7:0]  seg_n_q, seg_n_d;
  logic [5:0]  com_n_q, com_n_d;
  logic        tick;
  logic [23:0] live_digits;
  logic [3:0]  cur_digit;
  logic [6:0]  glyph;

  assign live_digits = {t_m1, t_m0, t_s1, t_s0, t_ms1, t_ms0};
  assign tick        = (presc_q == TICK_VAL);

  // Only BCD 0..9 have glyphs. The transient 10 seen during a carry, and any
  // other illegal code, shows as blank.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  // Prescaler: free-running 0..SCAN_DIV-1. It is independent of disp_en.
  always_comb begin
    presc_d = tick ? 16'd0 : presc_q + 16'd1;
  end

  // Scan FSM: step the digit index on each tick and take a fresh snapshot
  // at the start of every frame.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    snap_d  = snap_q;
    case (state_q)
      ST_OFF: begin
        if (tick) begin
          state_d = ST_SCAN;
          idx_d   = 3'd0;
          snap_d  = live_digits;
        end
      end
      ST_SCAN: begin
        if (tick) begin
          if (idx_q == 3'd5) begin
            idx_d  = 3'd0;
            snap_d = live_digits;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = ST_OFF;
        idx_d   = 3'd0;
      end
    endcase
  end

  // Select the snapshot digit for the current scan index.
  always_comb begin
    cur_digit = 4'd0;
    case (idx_q)
      3'd0:    cur_digit = snap_q[3:0];
      3'd1:    cur_digit = snap_q[7:4];
      3'd2:    cur_digit = snap_q[11:8];
      3'd3:    cur_digit = snap_q[15:12];
      3'd4:    cur_digit = snap_q[19:16];
      3'd5:    cur_digit = snap_q[23:20];
      default: cur_digit = 4'd0;
    endcase
  end

  // Glyph for the current digit, with optional leading-zero minute blanking.
  always_comb begin
    glyph = seg_decode(cur_digit);
`ifdef LEADING_ZERO_BLANK_EN
    if (idx_q == 3'd5 && snap_q[23:20] == 4'd0) begin
      glyph = 7'h7F;
    end
    if (idx_q == 3'd4 && snap_q[23:20] == 4'd0 && snap_q[19:16] == 4'd0) begin
      glyph = 7'h7F;
    end
`endif
  end

  // Output drive: dark unless scanning and enabled. The dp separates m.ss.cc
  // at indices 2 and 4, and it stays lit even when the digit is blanked.
  always_comb begin
    seg_n_d = 8'hFF;
    com_n_d = 6'h3F;
    if (state_q == ST_SCAN && disp_en) begin
      com_n_d = ~(6'd1 << idx_q);
      seg_n_d = {~((idx_q == 3'd2) || (idx_q == 3'd4)), glyph};
    end
  end

  // State and output registers. Reset blanks the display immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_OFF;
      presc_q <= 16'd0;
      idx_q   <= 3'd0;
      snap_q  <= 24'd0;
      seg_n_q <= 8'hFF;
      com_n_q <= 6'h3F;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      seg_n_q <= seg_n_d;
      com_n_q <= com_n_d;
    end
  end

  assign seg_n = seg_n_q;
  assign com_n = com_n_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with SCAN_DIV=4. Edge numbering counts
// rising edges after reset release. Digit i of frame k is visible from
// edge 5+24k+4i, and the snapshot is captured on edges 4+24k.
module tb_seg_scan_ctrl;

  logic       clk;
  logic       rst_n;
  logic       disp_en;
  logic [3:0] t_ms0, t_ms1, t_s0, t_s1, t_m0, t_m1;
  logic [7:0] seg_n;
  logic [5:0] com_n;

  int checks = 0;
  int errors = 0;
  int e      = 0;

  // Hand-written expected seg_n per display index for the latched frame
  // (snap_m) and for the inputs currently applied (exp_next).
  logic [7:0] snap_m   [6];
  logic [7:0] exp_next [6];
  logic [5:0] com_tab  [6] = '{6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F, 6'h1F};

  seg_scan_ctrl #(.SCAN_DIV(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .disp_en (disp_en),
    .t_ms0   (t_ms0),
    .t_ms1   (t_ms1),
    .t_s0    (t_s0),
    .t_s1    (t_s1),
    .t_m0    (t_m0),
    .t_m1    (t_m1),
    .seg_n   (seg_n),
    .com_n   (com_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_out(input string tag, input logic [7:0] es, input logic [5:0] ec);
    checks++;
    assert (seg_n === es) else begin
      errors++;
      $error("FAIL %s edge %0d seg_n got %h want %h", tag, e, seg_n, es);
    end
    checks++;
    assert (com_n === ec) else begin
      errors++;
      $error("FAIL %s edge %0d com_n got %h want %h", tag, e, com_n, ec);
    end
  endtask

  // Advance one edge, check the outputs, then roll the frame model on
  // capture edges.
  task automatic step_check();
    int ix;
    @(posedge clk);
    #1;
    e++;
    if (e < 5 || !disp_en) begin
      chk_out("off", 8'hFF, 6'h3F);
    end else begin
      ix = ((e - 5) / 4) % 6;
      chk_out("scan", snap_m[ix], com_tab[ix]);
      $display("edge %0d idx %0d seg_n %h com_n %h", e, ix, seg_n, com_n);
    end
    if (e >= 4 && ((e - 4) % 24) == 0) begin
      for (int i = 0; i < 6; i++) snap_m[i] = exp_next[i];
    end
  endtask

  task automatic run_to(input int target);
    while (e < target) step_check();
  endtask

  initial begin
    rst_n   = 1'b0;
    disp_en = 1'b1;
    t_ms0 = 4'd1; t_ms1 = 4'd2; t_s0 = 4'd3;
    t_s1  = 4'd4; t_m0  = 4'd5; t_m1 = 4'd6;
    exp_next = '{8'hF9, 8'hA4, 8'h30, 8'h99, 8'h12, 8'h82};
    snap_m   = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};

    // Held in reset across a few edges.
    repeat (3) @(posedge clk);
    #1;
    chk_out("reset", 8'hFF, 6'h3F);
    $display("reset seg_n %h com_n %h", seg_n, com_n);

    // Release between edges; outputs dark through edge 4, digit 0 at edge 5.
    @(negedge clk);
    rst_n = 1'b1;
    run_to(4);
    run_to(40);

    // Snapshot coherence: t_ms0 changes while idx=3 of frame 1.
    run_to(41);
    t_ms0 = 4'd7;
    exp_next[0] = 8'hF8;
    run_to(56);

    // Invalid code 10 on t_s1: frame 3 index 3 blank, frame 2 unaffected.
    t_s1 = 4'd10;
    exp_next[3] = 8'hFF;
    run_to(92);
    t_s1 = 4'd4;
    exp_next[3] = 8'h99;

    // Display disable while idx 2 is shown in frame 4, re-enable after 5 cycles.
    run_to(109);
    disp_en = 1'b0;
    run_to(114);
    disp_en = 1'b1;
    run_to(124);

    // Leading zero minutes, latched at edge 148 and shown in frame 6.
    t_m1 = 4'd0;
    t_m0 = 4'd0;
`ifdef LEADING_ZERO_BLANK_EN
    exp_next[4] = 8'h7F;
    exp_next[5] = 8'hFF;
`else
    exp_next[4] = 8'h40;
    exp_next[5] = 8'hC0;
`endif
    run_to(172);

    // Asynchronous reset mid-scan: outputs dark without a clock edge.
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_out("async_rst", 8'hFF, 6'h3F);
    $display("async reset seg_n %h com_n %h", seg_n, com_n);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
